// File: rtl/bus_pkg.sv
// Shared definitions for the CPU memory bus arbiter: FSM encoding, arbitration
// modes and default bus widths.
package bus_pkg;

  typedef enum logic [1:0] {
    BUS_IDLE  = 2'd0,
    BUS_ISSUE = 2'd1,
    BUS_WAIT  = 2'd2
  } bus_state_e;

  localparam int ARB_FIXED  = 0;
  localparam int ARB_RR     = 1;
  localparam int BUS_ADDR_W = 27;
  localparam int BUS_DATA_W = 32;

endpackage

// File: rtl/arb_picker.sv
// Combinational request selector: lowest pending index (fixed) or first pending
// index above last_grant with wrap-around (round-robin).
module arb_picker
  import bus_pkg::*;
#(
  parameter  int N     = 2,
  parameter  int MODE  = ARB_FIXED,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     pend,
  input  logic [IDX_W-1:0] last_grant,
  output logic             valid,
  output logic [IDX_W-1:0] index
);

  logic found;
  int   j;

  // Fixed priority scans 0..N-1; round-robin scans last_grant+1.. modulo N.
  always_comb begin
    valid = |pend;
    index = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 1; k <= N; k++) begin
      j = (MODE == ARB_RR) ? (int'(last_grant) + k) % N : k - 1;
      if (!found && pend[j]) begin
        found = 1'b1;
        index = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// N-master request buffer and arbiter in front of the single-slave memory bus,
// with per-master response routing and an optional transaction watchdog.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int N_MASTERS = 2,
  parameter int ADDR_W    = BUS_ADDR_W,
  parameter int DATA_W    = BUS_DATA_W,
  parameter int ARB_MODE  = ARB_FIXED,
  parameter int TIMEOUT   = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [N_MASTERS*ADDR_W-1:0]   m_addr,
  input  logic [N_MASTERS*DATA_W-1:0]   m_data,
  input  logic [N_MASTERS-1:0]          m_we,
  input  logic [N_MASTERS-1:0]          m_start,
  output logic [DATA_W-1:0]             m_q,
  output logic [N_MASTERS-1:0]          m_done,
  output logic [N_MASTERS-1:0]          m_err,
  output logic [ADDR_W-1:0]             s_addr,
  output logic [DATA_W-1:0]             s_data,
  output logic                          s_we,
  output logic                          s_start,
  input  logic [DATA_W-1:0]             s_q,
  input  logic                          s_done
);

  localparam int IDX_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  bus_state_e           state, state_next;
  logic [N_MASTERS-1:0] pend, set, clr;
  logic [IDX_W-1:0]     grant, last_grant, pick_idx;
  logic [CNT_W-1:0]     wd_cnt;
  logic                 pick_valid, take, fin, tmo;

  logic [ADDR_W-1:0]    buf_addr [N_MASTERS];
  logic [DATA_W-1:0]    buf_data [N_MASTERS];
  logic                 buf_we   [N_MASTERS];

  arb_picker #(.N(N_MASTERS), .MODE(ARB_MODE)) u_pick (
    .pend       (pend),
    .last_grant (last_grant),
    .valid      (pick_valid),
    .index      (pick_idx)
  );

  // A start landing on the cycle its pend bit is granted away is a new request.
  assign clr = take ? (N_MASTERS'(1) << pick_idx) : '0;
  assign set = m_start & (~pend | clr);

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_MASTERS; i++) begin
      if (set[i]) begin
        buf_addr[i] <= m_addr[i*ADDR_W +: ADDR_W];
        buf_data[i] <= m_data[i*DATA_W +: DATA_W];
        buf_we[i]   <= m_we[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= BUS_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    take       = 1'b0;
    fin        = 1'b0;
    tmo        = 1'b0;
    unique case (state)
      BUS_IDLE: if (pick_valid) begin
        take       = 1'b1;
        state_next = BUS_ISSUE;
      end
      BUS_ISSUE: if (s_done) begin
        fin        = 1'b1;
        state_next = BUS_IDLE;
      end else begin
        state_next = BUS_WAIT;
      end
      BUS_WAIT: if (s_done) begin
        fin        = 1'b1;
        state_next = BUS_IDLE;
      end else if (TIMEOUT != 0 && wd_cnt == CNT_W'(TIMEOUT - 1)) begin
        tmo        = 1'b1;
        state_next = BUS_IDLE;
      end
      default: state_next = BUS_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend       <= '0;
      grant      <= '0;
      last_grant <= IDX_W'(N_MASTERS - 1);
      wd_cnt     <= '0;
      s_addr     <= '0;
      s_data     <= '0;
      s_we       <= 1'b0;
      s_start    <= 1'b0;
      m_q        <= '0;
      m_done     <= '0;
      m_err      <= '0;
    end else begin
      pend    <= (pend & ~clr) | set;
      s_start <= take;
      m_done  <= '0;
      m_err   <= '0;
      m_q     <= '0;
      if (take) begin
        s_addr     <= buf_addr[pick_idx];
        s_data     <= buf_data[pick_idx];
        s_we       <= buf_we[pick_idx];
        grant      <= pick_idx;
        last_grant <= pick_idx;
      end
      // Counter is zeroed during ISSUE so WAIT cycles count from 0.
      if (state == BUS_ISSUE)     wd_cnt <= '0;
      else if (state == BUS_WAIT) wd_cnt <= wd_cnt + 1'b1;
      if (fin) begin
        m_done[grant] <= 1'b1;
        m_q           <= s_q;
      end
      if (tmo) begin
        m_done[grant] <= 1'b1;
        m_err[grant]  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed latency/priority/watchdog/reset scenarios on a
// 2-master fixed-priority instance, ordering and randomized traffic on a 3-master RR instance.
module tb_bus_arbiter;
  localparam int AW = 27;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance A: 2 masters, fixed priority, watchdog 8
  logic [2*AW-1:0] a_m_addr;  logic [2*DW-1:0] a_m_data;
  logic [1:0] a_m_we, a_m_start, a_m_done, a_m_err;
  logic [DW-1:0] a_m_q, a_s_data, a_s_q;
  logic [AW-1:0] a_s_addr;
  logic a_s_we, a_s_start, a_s_done;

  // Instance B: 3 masters, round-robin, no watchdog
  logic [3*AW-1:0] b_m_addr;  logic [3*DW-1:0] b_m_data;
  logic [2:0] b_m_we, b_m_start, b_m_done, b_m_err;
  logic [DW-1:0] b_m_q, b_s_data, b_s_q;
  logic [AW-1:0] b_s_addr;
  logic b_s_we, b_s_start, b_s_done;

  int checks = 0;
  int failures = 0;

  bus_arbiter #(.N_MASTERS(2), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(0), .TIMEOUT(8)) dut_a (
    .clk(clk), .reset(rst_n), .m_addr(a_m_addr), .m_data(a_m_data), .m_we(a_m_we),
    .m_start(a_m_start), .m_q(a_m_q), .m_done(a_m_done), .m_err(a_m_err),
    .s_addr(a_s_addr), .s_data(a_s_data), .s_we(a_s_we), .s_start(a_s_start),
    .s_q(a_s_q), .s_done(a_s_done));

  bus_arbiter #(.N_MASTERS(3), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(1), .TIMEOUT(0)) dut_b (
    .clk(clk), .reset(rst_n), .m_addr(b_m_addr), .m_data(b_m_data), .m_we(b_m_we),
    .m_start(b_m_start), .m_q(b_m_q), .m_done(b_m_done), .m_err(b_m_err),
    .s_addr(b_s_addr), .s_data(b_s_data), .s_we(b_s_we), .s_start(b_s_start),
    .s_q(b_s_q), .s_done(b_s_done));

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    a_m_addr = '0; a_m_data = '0; a_m_we = '0; a_m_start = '0; a_s_q = '0; a_s_done = 1'b0;
    b_m_addr = '0; b_m_data = '0; b_m_we = '0; b_m_start = '0; b_s_q = '0; b_s_done = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if ({a_m_done, a_m_err, a_s_start, a_s_we} !== 6'b0) begin failures++; $display("FAIL reset_a_ctl got=%b exp=0", {a_m_done, a_m_err, a_s_start, a_s_we}); end
    checks++; if ({a_m_q, a_s_addr, a_s_data} !== '0) begin failures++; $display("FAIL reset_a_data got=%h exp=0", {a_m_q, a_s_addr, a_s_data}); end
    checks++; if ({b_m_done, b_m_err, b_s_start, b_s_we, b_m_q, b_s_addr, b_s_data} !== '0) begin failures++; $display("FAIL reset_b got=%h exp=0", {b_m_done, b_m_err, b_s_start, b_s_we, b_m_q, b_s_addr, b_s_data}); end
  endtask

  task automatic test_read_latency();
    apply_reset();
    a_m_addr[0 +: AW] = 27'h100; a_m_we = 2'b00; a_m_start = 2'b01;       // cycle 0
    tick(); a_m_start = 2'b00;                                            // cycle 1
    checks++; if (a_s_start !== 1'b0) begin failures++; $display("FAIL rd_sstart_c1 got=%b exp=0", a_s_start); end
    tick();                                                               // cycle 2
    checks++; if ({a_s_start, a_s_we, a_s_addr} !== {1'b1, 1'b0, 27'h100}) begin failures++; $display("FAIL rd_issue got=%b/%b/%h exp=1/0/100", a_s_start, a_s_we, a_s_addr); end
    tick(); tick(); tick();                                               // cycle 5
    a_s_done = 1'b1; a_s_q = 32'hDEADBEEF;
    tick(); a_s_done = 1'b0; a_s_q = '0;                                  // cycle 6
    checks++; if ({a_m_done, a_m_err, a_m_q} !== {2'b01, 2'b00, 32'hDEADBEEF}) begin failures++; $display("FAIL rd_done got=%b/%b/%h exp=01/00/deadbeef", a_m_done, a_m_err, a_m_q); end
    tick();
    checks++; if (a_m_done !== 2'b00) begin failures++; $display("FAIL rd_done_pulse got=%b exp=00", a_m_done); end
  endtask

  task automatic test_same_cycle();
    apply_reset();
    a_m_addr[0 +: AW] = 27'h11; a_m_addr[AW +: AW] = 27'h22; a_m_start = 2'b11;
    tick(); a_m_start = 2'b00;
    tick();                                                               // cycle 2
    checks++; if ({a_s_start, a_s_addr} !== {1'b1, 27'h11}) begin failures++; $display("FAIL prio_first got=%b/%h exp=1/11", a_s_start, a_s_addr); end
    tick(); a_s_done = 1'b1; a_s_q = 32'h1;                               // cycle 3
    tick(); a_s_done = 1'b0;                                              // cycle 4
    checks++; if ({a_m_done, a_s_start} !== {2'b01, 1'b0}) begin failures++; $display("FAIL prio_done0 got=%b/%b exp=01/0", a_m_done, a_s_start); end
    tick();                                                               // cycle 5
    checks++; if ({a_s_start, a_s_addr} !== {1'b1, 27'h22}) begin failures++; $display("FAIL prio_second got=%b/%h exp=1/22", a_s_start, a_s_addr); end
    a_s_done = 1'b1; a_s_q = 32'h2;                                       // accepted during ISSUE
    tick(); a_s_done = 1'b0;                                              // cycle 6
    checks++; if ({a_m_done, a_m_q} !== {2'b10, 32'h2}) begin failures++; $display("FAIL prio_done1 got=%b/%h exp=10/2", a_m_done, a_m_q); end
  endtask

  task automatic test_timeout();
    int early;
    early = 0;
    apply_reset();
    a_m_addr[0 +: AW] = 27'hA; a_m_addr[AW +: AW] = 27'hB; a_m_start = 2'b11; a_s_q = 32'hFFFFFFFF;
    tick(); a_m_start = 2'b00;
    tick();                                                               // cycle 2
    checks++; if ({a_s_start, a_s_addr} !== {1'b1, 27'hA}) begin failures++; $display("FAIL wd_issue got=%b/%h exp=1/a", a_s_start, a_s_addr); end
    for (int c = 3; c <= 10; c++) begin
      tick();
      if (a_m_done !== 2'b00 || a_m_err !== 2'b00) early++;
    end
    checks++; if (early !== 0) begin failures++; $display("FAIL wd_early got=%0d exp=0", early); end
    tick();                                                               // cycle 11
    checks++; if ({a_m_done, a_m_err, a_m_q} !== {2'b01, 2'b01, 32'h0}) begin failures++; $display("FAIL wd_fire got=%b/%b/%h exp=01/01/0", a_m_done, a_m_err, a_m_q); end
    tick();                                                               // cycle 12
    checks++; if ({a_s_start, a_s_addr, a_m_err} !== {1'b1, 27'hB, 2'b00}) begin failures++; $display("FAIL wd_next got=%b/%h/%b exp=1/b/00", a_s_start, a_s_addr, a_m_err); end
    a_s_done = 1'b1; a_s_q = 32'h5;
    tick(); a_s_done = 1'b0;
    checks++; if ({a_m_done, a_m_err, a_m_q} !== {2'b10, 2'b00, 32'h5}) begin failures++; $display("FAIL wd_after got=%b/%b/%h exp=10/00/5", a_m_done, a_m_err, a_m_q); end
  endtask

  task automatic test_double_start();
    int extra;
    extra = 0;
    apply_reset();
    a_m_addr[0 +: AW] = 27'h1; a_m_start = 2'b01;                         // cycle 0
    tick();                                                               // cycle 1
    a_m_addr[AW +: AW] = 27'h4000000; a_m_data[DW +: DW] = 32'h12345678; a_m_we = 2'b10; a_m_start = 2'b10;
    tick(); a_m_start = 2'b00;                                            // cycle 2
    tick();                                                               // cycle 3: dropped
    a_m_addr[AW +: AW] = 27'h7; a_m_data[DW +: DW] = 32'hBAD; a_m_we = 2'b00; a_m_start = 2'b10;
    tick(); a_m_start = 2'b00; a_s_done = 1'b1;                           // cycle 4
    tick(); a_s_done = 1'b0;                                              // cycle 5
    checks++; if (a_m_done !== 2'b01) begin failures++; $display("FAIL dbl_done0 got=%b exp=01", a_m_done); end
    tick();                                                               // cycle 6
    checks++; if ({a_s_start, a_s_we, a_s_addr, a_s_data} !== {1'b1, 1'b1, 27'h4000000, 32'h12345678}) begin failures++; $display("FAIL dbl_write got=%b/%b/%h/%h exp=1/1/4000000/12345678", a_s_start, a_s_we, a_s_addr, a_s_data); end
    a_s_done = 1'b1;
    tick(); a_s_done = 1'b0;
    checks++; if (a_m_done !== 2'b10) begin failures++; $display("FAIL dbl_done1 got=%b exp=10", a_m_done); end
    for (int c = 0; c < 10; c++) begin tick(); if (a_s_start) extra++; end
    checks++; if (extra !== 0) begin failures++; $display("FAIL dbl_extra got=%0d exp=0", extra); end
  endtask

  task automatic test_restart_on_grant();
    apply_reset();
    a_m_addr[0 +: AW] = 27'h33; a_m_start = 2'b01;                        // cycle 0
    tick(); a_m_addr[0 +: AW] = 27'h55; a_m_start = 2'b01;                // cycle 1: grant clears pend[0]
    tick(); a_m_start = 2'b00;                                            // cycle 2
    checks++; if ({a_s_start, a_s_addr} !== {1'b1, 27'h33}) begin failures++; $display("FAIL rog_first got=%b/%h exp=1/33", a_s_start, a_s_addr); end
    a_s_done = 1'b1;
    tick(); a_s_done = 1'b0;                                              // cycle 3
    tick();                                                               // cycle 4
    checks++; if ({a_s_start, a_s_addr} !== {1'b1, 27'h55}) begin failures++; $display("FAIL rog_second got=%b/%h exp=1/55", a_s_start, a_s_addr); end
    a_s_done = 1'b1;
    tick(); a_s_done = 1'b0;
    checks++; if (a_m_done !== 2'b01) begin failures++; $display("FAIL rog_done got=%b exp=01", a_m_done); end
  endtask

  task automatic test_reset_mid();
    int stray;
    stray = 0;
    apply_reset();
    a_m_addr[0 +: AW] = 27'h3; a_m_data[0 +: DW] = 32'h77; a_m_we = 2'b01; a_m_start = 2'b01;
    tick(); a_m_addr[AW +: AW] = 27'h9; a_m_start = 2'b10;                // cycle 1
    tick(); a_m_start = 2'b00;                                            // cycle 2
    checks++; if ({a_s_start, a_s_addr} !== {1'b1, 27'h3}) begin failures++; $display("FAIL rmid_issue got=%b/%h exp=1/3", a_s_start, a_s_addr); end
    tick(); rst_n = 1'b0; #1;                                             // cycle 3, in WAIT
    checks++; if ({a_s_start, a_s_we, a_s_addr, a_s_data, a_m_q, a_m_done, a_m_err} !== '0) begin failures++; $display("FAIL rmid_outs got=%h exp=0", {a_s_start, a_s_we, a_s_addr, a_s_data, a_m_q, a_m_done, a_m_err}); end
    tick(); rst_n = 1'b1;
    tick(); a_s_done = 1'b1; a_s_q = 32'hAA;
    for (int c = 0; c < 8; c++) begin
      tick(); a_s_done = 1'b0;
      if (a_m_done !== 2'b00 || a_s_start !== 1'b0) stray++;
    end
    checks++; if (stray !== 0) begin failures++; $display("FAIL rmid_stray got=%0d exp=0", stray); end
  endtask

  task automatic test_rr_order();
    int t;
    logic resp;
    t = 0; resp = 1'b0;
    apply_reset();
    for (int i = 0; i < 3; i++) b_m_addr[i*AW +: AW] = AW'(i);
    b_m_start = 3'b111;
    for (int c = 0; c < 400 && t < 9; c++) begin
      tick();
      b_m_start = 3'b000;
      b_s_done = resp;
      resp = b_s_start;
      if (b_s_start) begin
        checks++; if (b_s_addr !== AW'(t % 3)) begin failures++; $display("FAIL rr_order[%0d] got=%0d exp=%0d", t, b_s_addr, t % 3); end
        t++;
      end
      for (int i = 0; i < 3; i++) if (b_m_done[i]) b_m_start[i] = 1'b1;
    end
    checks++; if (t !== 9) begin failures++; $display("FAIL rr_count got=%0d exp=9", t); end
  endtask

  // Transaction-level model: masters start only when idle; a request issued at
  // cycle e must have started by e-2 and is picked round-robin from last grant.
  task automatic test_random_rr();
    logic [AW-1:0] raddr [3];
    logic [DW-1:0] rdata [3];
    logic          rwe   [3];
    bit            outst [3];
    bit            issued[3];
    int            st_cyc[3];
    logic [DW-1:0] exp_q;
    logic [2:0]    exp_mask;
    int last, cyc, ntx, cnt, cur, done_at, g, exp_m;
    bit busy;
    last = 2; cyc = 0; ntx = 0; cnt = 0; cur = 0; done_at = -1; exp_m = 0; busy = 0; exp_q = '0;
    for (int i = 0; i < 3; i++) begin outst[i] = 0; issued[i] = 0; st_cyc[i] = 0; end
    apply_reset();
    while (ntx < 60 && cyc < 3000) begin
      tick();
      exp_mask = '0;
      if (cyc == done_at) exp_mask[exp_m] = 1'b1;
      checks++; if ({b_m_err, b_m_done} !== {3'b000, exp_mask}) begin failures++; $display("FAIL rnd_done c=%0d got=%b/%b exp=000/%b", cyc, b_m_err, b_m_done, exp_mask); end
      if (cyc == done_at) begin
        checks++; if (b_m_q !== exp_q) begin failures++; $display("FAIL rnd_q c=%0d got=%h exp=%h", cyc, b_m_q, exp_q); end
        outst[exp_m] = 0; ntx++;
      end
      if (b_s_start) begin
        g = -1;
        for (int k = 1; k <= 3; k++) begin
          int j;
          j = (last + k) % 3;
          if (g < 0 && outst[j] && !issued[j] && st_cyc[j] <= cyc - 2) g = j;
        end
        checks++;
        if (g < 0 || busy) begin
          failures++; $display("FAIL rnd_grant c=%0d got=unexpected s_start exp=none", cyc);
        end else if ({b_s_addr, b_s_data, b_s_we} !== {raddr[g], rdata[g], rwe[g]}) begin
          failures++; $display("FAIL rnd_req c=%0d got=%h/%h/%b exp=%h/%h/%b (m%0d)", cyc, b_s_addr, b_s_data, b_s_we, raddr[g], rdata[g], rwe[g], g);
        end
        if (g >= 0) begin issued[g] = 1; last = g; cur = g; end
        busy = 1; cnt = $urandom_range(0, 4);
      end
      b_s_done = 1'b0;
      if (busy) begin
        if (cnt == 0) begin
          b_s_done = 1'b1; b_s_q = $urandom; exp_q = b_s_q; exp_m = cur; done_at = cyc + 1; busy = 0;
        end else cnt--;
      end
      b_m_start = 3'b000;
      for (int i = 0; i < 3; i++) begin
        if (!outst[i] && $urandom_range(0, 2) == 0) begin
          raddr[i] = AW'($urandom); rdata[i] = $urandom; rwe[i] = 1'($urandom);
          b_m_addr[i*AW +: AW] = raddr[i]; b_m_data[i*DW +: DW] = rdata[i]; b_m_we[i] = rwe[i];
          b_m_start[i] = 1'b1; outst[i] = 1; issued[i] = 0; st_cyc[i] = cyc;
        end
      end
      cyc++;
    end
    checks++; if (ntx !== 60) begin failures++; $display("FAIL rnd_ntx got=%0d exp=60", ntx); end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout got=hung exp=finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    test_reset();
    test_read_latency();
    test_same_cycle();
    test_timeout();
    test_double_start();
    test_restart_on_grant();
    test_reset_mid();
    test_rr_order();
    test_random_rr();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
